// File: rtl/spi_slave_fsm.sv
// SPI mode-0 slave protocol engine: decodes address + R/W, then one data byte,
// and drives a sync-write / comb-read register-file port plus MISO.
module spi_slave_fsm #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs_cond,
  input  logic                  sclk_posedge,
  input  logic                  sclk_negedge,
  input  logic                  mosi_cond,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  miso,
  output logic                  miso_en,
  output logic                  busy
);

  localparam int SHIFT_WIDTH = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_WIDTH);
  localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    READ_LOAD    = 3'd2,
    READ_SHIFT   = 3'd3,
    WRITE_GET    = 3'd4,
    WRITE_COMMIT = 3'd5,
    DONE         = 3'd6
  } state_t;

  state_t                  state_reg, state_next;
  logic [SHIFT_WIDTH-1:0]  shift_reg, shift_next;
  logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic                    miso_reg, miso_next;
  logic [SHIFT_WIDTH-1:0]  shift_in;

  // Shift register with the current MOSI bit appended at the LSB (MSB-first framing).
  assign shift_in = {shift_reg[SHIFT_WIDTH-2:0], mosi_cond};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      miso_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      miso_reg  <= miso_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    miso_next  = miso_reg;

    // A deasserted chip select overrides every other event in the same cycle.
    if (cs_cond) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = GET_ADDR;
          cnt_next   = '0;
        end

        GET_ADDR: begin
          if (sclk_posedge) begin
            shift_next = shift_in;
            if (cnt_reg == ADDR_LAST) begin
              // Address bits are already in the register; the incoming bit is R/W.
              addr_next  = shift_reg[ADDR_WIDTH-1:0];
              cnt_next   = '0;
              state_next = mosi_cond ? READ_LOAD : WRITE_GET;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end

        READ_LOAD: begin
          shift_next = SHIFT_WIDTH'(mem_rdata);
          state_next = READ_SHIFT;
        end

        READ_SHIFT: begin
          if (sclk_negedge) begin
            miso_next  = shift_reg[DATA_WIDTH-1];
            shift_next = shift_reg << 1;
          end
          if (sclk_posedge) begin
            if (cnt_reg == DATA_LAST) begin
              cnt_next   = '0;
              state_next = DONE;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end

        WRITE_GET: begin
          if (sclk_posedge) begin
            shift_next = shift_in;
            if (cnt_reg == DATA_LAST) begin
              wdata_next = shift_in[DATA_WIDTH-1:0];
              cnt_next   = '0;
              state_next = WRITE_COMMIT;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end

        WRITE_COMMIT: begin
          state_next = DONE;
        end

        DONE: begin
          state_next = DONE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // The strobe is also masked by CS so a commit cycle that coincides with CS rising writes nothing.
  assign mem_we    = (state_reg == WRITE_COMMIT) && !cs_cond;
  assign miso_en   = (state_reg == READ_SHIFT);
  assign busy      = (state_reg != IDLE);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign miso      = miso_reg;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Bench for spi_slave_fsm: transaction-level model compared every clk, plus literal checks.
module tb_spi_slave_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_cond = 1'b1;
  logic       sclk_posedge = 1'b0;
  logic       sclk_negedge = 1'b0;
  logic       mosi_cond = 1'b0;
  logic [7:0] mem_rdata;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       miso;
  logic       miso_en;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int we_total = 0;
  int base = 0;
  logic [7:0] rd_cap = 8'h00;

  logic [7:0] rf [0:127];
  logic [7:0] model_mem [0:127];

  // model state: what the protocol rules say, counted in SCLK bits per CS frame
  logic       m_busy = 1'b0;
  int         m_n = 0;
  logic       rx [0:15];
  int         m_since8 = 0;
  logic [6:0] m_addr = 7'h00;
  logic [7:0] m_wdata = 8'h00;
  logic       m_commit = 1'b0;
  logic       m_miso = 1'b0;
  logic [7:0] m_rbyte = 8'h00;
  int         m_k = 0;
  logic       pre_shift;

  always #5 clk = ~clk;

  spi_slave_fsm dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cs_cond      (cs_cond),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .mosi_cond    (mosi_cond),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .miso         (miso),
    .miso_en      (miso_en),
    .busy         (busy)
  );

  assign mem_rdata = rf[mem_addr];

  always @(posedge clk) if (reset_n && mem_we) we_total <= we_total + 1;

  initial begin : regfile
    for (int i = 0; i < 128; i++) rf[i] = 8'(i * 7 + 1);
    rf[42] = 8'hA5;
    forever begin
      @(posedge clk);
      if (mem_we) rf[mem_addr] = mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read data is on the wire once the byte is loaded and until the 16th bit.
  function automatic logic m_shifting();
    return m_busy && (m_n >= 8) && (m_n < 16) && (rx[7] == 1'b1) && (m_since8 >= 1);
  endfunction

  initial begin : model
    for (int i = 0; i < 128; i++) model_mem[i] = 8'(i * 7 + 1);
    model_mem[42] = 8'hA5;
    for (int i = 0; i < 16; i++) rx[i] = 1'b0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_busy = 1'b0; m_n = 0; m_since8 = 0; m_addr = 7'h00; m_wdata = 8'h00;
        m_commit = 1'b0; m_miso = 1'b0; m_k = 0;
      end else begin
        pre_shift = m_shifting();
        if (cs_cond) begin
          m_busy = 1'b0; m_n = 0; m_commit = 1'b0;
        end else if (!m_busy) begin
          m_busy = 1'b1; m_n = 0; m_commit = 1'b0;
        end else begin
          if (m_commit) model_mem[m_addr] = m_wdata;
          m_commit = 1'b0;
          if (m_n >= 8) m_since8++;
          if (pre_shift && sclk_negedge && m_k < 8) begin
            m_miso = m_rbyte[7 - m_k];
            m_k++;
          end
          if (sclk_posedge && m_n < 16) begin
            rx[m_n] = mosi_cond;
            m_n++;
            if (m_n == 8) begin
              for (int i = 0; i < 7; i++) m_addr[6 - i] = rx[i];
              m_since8 = 0;
            end
            if (m_n == 16 && rx[7] == 1'b0) begin
              for (int i = 0; i < 8; i++) m_wdata[7 - i] = rx[8 + i];
              m_commit = 1'b1;
            end
          end
          if (m_n >= 8 && rx[7] == 1'b1 && m_since8 == 1) begin
            m_rbyte = model_mem[m_addr];
            m_k = 0;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("miso_en", 32'(miso_en), 32'(m_shifting()));
        check("mem_we", 32'(mem_we), 32'(m_commit && !cs_cond));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        check("miso", 32'(miso), 32'(m_miso));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCLK period: 4 clk low, rising pulse, 4 clk high, falling pulse.
  task automatic sclk_bit(input logic b, input logic cs_at_pos);
    mosi_cond = b;
    tick(3);
    sclk_posedge = 1'b1;
    rd_cap = {rd_cap[6:0], miso};
    if (cs_at_pos) cs_cond = 1'b1;
    tick(1);
    sclk_posedge = 1'b0;
    tick(3);
    sclk_negedge = 1'b1;
    tick(1);
    sclk_negedge = 1'b0;
  endtask

  task automatic txn(input logic [7:0] hdr, input logic [7:0] data, input int ndata,
                     input logic cs_last, input int extra);
    cs_cond = 1'b0;
    tick(2);
    for (int i = 7; i >= 0; i--) sclk_bit(hdr[i], 1'b0);
    for (int i = 0; i < ndata; i++) sclk_bit(data[7 - i], cs_last && (i == ndata - 1));
    for (int i = 0; i < extra; i++) sclk_bit(1'b1, 1'b0);
    tick(2);
  endtask

  task automatic cs_release();
    cs_cond = 1'b1;
    tick(2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("rst_busy", 32'(busy), 0);
    check("rst_miso_en", 32'(miso_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_miso", 32'(miso), 0);

    // read of 0x2A holding 0xA5
    base = we_total;
    txn(8'h55, 8'h00, 8, 1'b0, 0);
    check("read_data", 32'(rd_cap), 32'h0000_00A5);
    check("read_no_we", 32'(we_total - base), 0);
    check("read_addr", 32'(mem_addr), 32'h2A);
    cs_release();
    check("read_idle", 32'(busy), 0);
    $display("read  addr=0x2A data=0x%02h", rd_cap);

    // write 0xC3 to 0x2A
    base = we_total;
    txn(8'h54, 8'hC3, 8, 1'b0, 0);
    check("write_we_count", 32'(we_total - base), 1);
    check("write_addr", 32'(mem_addr), 32'h2A);
    check("write_wdata", 32'(mem_wdata), 32'hC3);
    check("write_rf", 32'(rf[42]), 32'hC3);
    cs_release();
    $display("write addr=0x2A data=0xC3 we_pulses=%0d", we_total - base);

    // asynchronous reset in the middle of the address phase
    cs_cond = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) sclk_bit(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_addr", 32'(mem_addr), 0);
    check("arst_wdata", 32'(mem_wdata), 0);
    check("arst_miso", 32'(miso), 0);
    check("arst_miso_en", 32'(miso_en), 0);
    check("arst_we", 32'(mem_we), 0);
    cs_cond = 1'b1;
    mosi_cond = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    $display("reset mid-address: busy=%0d addr=0x%02h", busy, mem_addr);

    // back-to-back write then read of 0x01, CS high for one clk between
    base = we_total;
    txn(8'h02, 8'h3C, 8, 1'b0, 0);
    cs_cond = 1'b1;
    tick(1);
    txn(8'h03, 8'h00, 8, 1'b0, 0);
    check("b2b_read", 32'(rd_cap), 32'h3C);
    check("b2b_we_count", 32'(we_total - base), 1);
    cs_release();
    $display("b2b   addr=0x01 wrote=0x3C read=0x%02h", rd_cap);

    // abort after 5 data bits
    base = we_total;
    txn(8'h54, 8'h99, 5, 1'b0, 0);
    cs_cond = 1'b1;
    tick(1);
    check("abort5_idle", 32'(busy), 0);
    tick(20);
    check("abort5_no_we", 32'(we_total - base), 0);
    check("abort5_wdata", 32'(mem_wdata), 32'h3C);
    $display("abort after 5 bits: we_pulses=%0d", we_total - base);

    // CS rises in the same clk as the 8th data posedge
    base = we_total;
    txn(8'h54, 8'h66, 8, 1'b1, 0);
    cs_release();
    check("abort8_no_we", 32'(we_total - base), 0);
    check("abort8_wdata", 32'(mem_wdata), 32'h3C);
    $display("abort on last bit: we_pulses=%0d", we_total - base);

    // four extra SCLK cycles while DONE
    base = we_total;
    txn(8'h54, 8'h5A, 8, 1'b0, 4);
    check("extra_busy", 32'(busy), 1);
    check("extra_miso_en", 32'(miso_en), 0);
    check("extra_we_count", 32'(we_total - base), 1);
    check("extra_wdata", 32'(mem_wdata), 32'h5A);
    cs_release();
    check("extra_idle", 32'(busy), 0);
    $display("extra clocks: wdata=0x%02h we_pulses=%0d", mem_wdata, we_total - base);

    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
- Protocol engine of the SPI slave peripheral.
- Sits directly downstream of the input conditioners for SCLK, MOSI and CS: it consumes their conditioned levels and single-clk edge pulses.
- Decodes one SPI mode-0 transaction per CS assertion: 7-bit address plus R/W bit, then one data byte.
- Drives a synchronous-write / combinational-read register-file port and the MISO output and its tristate enable.

Parameters:
- ADDR_WIDTH, 7, register-file address bits. Address phase is ADDR_WIDTH+1 bits long.
- DATA_WIDTH, 8, data phase bits.
- CNT_WIDTH, 4, bit-counter width. Must satisfy 2^CNT_WIDTH > max(ADDR_WIDTH+1, DATA_WIDTH).

Ports:
- clk  in  1  system clock; same domain as the conditioners.
- reset_n  in  1  asynchronous, active-low reset.
- cs_cond  in  1  conditioned chip select, active low.
- sclk_posedge  in  1  one-clk pulse on each conditioned SCLK rising edge.
- sclk_negedge  in  1  one-clk pulse on each conditioned SCLK falling edge.
- mosi_cond  in  1  conditioned MOSI level.
- mem_rdata  in  DATA_WIDTH  combinational read data for mem_addr.
- mem_addr  out  ADDR_WIDTH  registered transaction address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_we  out  1  one-clk write strobe.
- miso  out  1  serial read data.
- miso_en  out  1  MISO tristate-buffer enable.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0) clears state, shift register, bit counter, mem_addr, mem_wdata, mem_we, miso, miso_en and busy to 0; state goes to IDLE. Reset mid-transaction aborts it with no write.
- Abort: cs_cond=1 in any state forces IDLE on the next clk. Takes priority over every other event in the same cycle, including the last data bit or a pending commit. Counter clears; no mem_we is issued.
- IDLE: SCLK pulses are ignored. On cs_cond=0, go to GET_ADDR with counter=0. An sclk_posedge in that same cycle is ignored.
- GET_ADDR:
  - Each sclk_posedge shifts mosi_cond into the shift-register LSB (MSB first) and increments the counter.
  - On the (ADDR_WIDTH+1)-th posedge, in the same clk: mem_addr <= first ADDR_WIDTH bits; rw <= last bit (1 = read); counter clears.
  - Next state is READ_LOAD if rw=1, else WRITE_GET.
- READ_LOAD (exactly 1 clk): shift register <= mem_rdata, sampled with the new mem_addr. Go to READ_SHIFT.
- READ_SHIFT:
  - miso_en=1 throughout.
  - Each sclk_negedge: miso <= shift-register MSB, then shift left by 1.
  - Each sclk_posedge increments the counter. On the DATA_WIDTH-th posedge go to DONE.
  - Consequence: the data MSB appears on the falling edge that follows the R/W-bit rising edge, and the master samples it on the next rising edge (mode 0).
- WRITE_GET: shift on sclk_posedge as in GET_ADDR. On the DATA_WIDTH-th posedge: mem_wdata <= assembled byte; go to WRITE_COMMIT.
- WRITE_COMMIT (exactly 1 clk): mem_we=1. Go to DONE.
- DONE: all SCLK/MOSI activity is ignored. miso_en=0 and miso holds its value. Wait for cs_cond=1, then IDLE.
- Outputs outside their active phase: miso_en=0 in all states except READ_SHIFT; mem_we=0 in all states except WRITE_COMMIT.
- Timing assumption: SCLK high and low times are each at least 4 clk after conditioning, which guarantees READ_LOAD completes before the first data negedge. Faster SCLK is out of scope and is not checked.
- mem_addr holds its value after the transaction until the next address capture.

Test Plan:
- Reset: assert reset_n=0 mid-GET_ADDR -> all outputs 0 and state IDLE immediately, without waiting for a clk edge; the next transaction decodes normally.
- Write: CS low, shift 0x54 (addr 0x2A, W), then data 0xC3 -> exactly one mem_we pulse with mem_addr=0x2A and mem_wdata=0xC3, one clk after the 16th posedge pulse; miso_en stays 0.
- Read: mem_rdata=0xA5 at addr 0x2A; shift 0x55 (addr 0x2A, R) -> miso presents 1,0,1,0,0,1,0,1 on the 8 falling edges; miso_en=1 only in READ_SHIFT; no mem_we.
- Abort: in a write, raise CS after 5 data bits -> IDLE next clk and no mem_we. Raising CS in the same clk as the 8th data posedge also gives no mem_we.
- Extra clocks: 4 extra SCLK cycles in DONE -> no state change, no mem_we, miso_en=0; CS high -> IDLE, busy=0.
- Back-to-back: a write to 0x01, then a read of 0x01 with CS high for 1 clk between -> the read returns the written byte, using a bench register-file model.
